// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Define ALU_ARB_CC_EN to build the ZF/SF/OF condition-code registers.
module alu_arbiter #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [1:0]   alu_ctrl,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_ans,
  input  logic         alu_ovf,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_ovf,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e state_q, state_d;
  logic   rr_q, rr_d;
  logic   gnt0, gnt1;
  logic   accept;

  // rr names the requester that wins when both are valid.
  always_comb begin
    gnt0 = req0_valid & (~req1_valid | ~rr_q);
    gnt1 = req1_valid & (~req0_valid | rr_q);
  end

  assign req0_ready = (state_q == StIdle) & gnt0;
  assign req1_ready = (state_q == StIdle) & gnt1;
  assign accept     = req0_ready | req1_ready;
  assign rsp_valid  = (state_q == StResp);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StExec;
          rr_d    = ~req1_ready;
        end
      end
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // ALU operands are held after EXEC until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl <= 2'b00;
      alu_a    <= '0;
      alu_b    <= '0;
      rsp_id   <= 1'b0;
    end else if (accept) begin
      alu_ctrl <= req1_ready ? req1_op : req0_op;
      alu_a    <= req1_ready ? req1_a  : req0_a;
      alu_b    <= req1_ready ? req1_b  : req0_b;
      rsp_id   <= req1_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_ovf  <= 1'b0;
    end else if (state_q == StExec) begin
      rsp_data <= alu_ans;
      rsp_ovf  <= alu_ovf;
    end
  end

`ifdef ALU_ARB_CC_EN
  logic cc_zf_q, cc_sf_q, cc_of_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_zf_q <= 1'b0;
      cc_sf_q <= 1'b0;
      cc_of_q <= 1'b0;
    end else if (state_q == StExec) begin
      cc_zf_q <= (alu_ans == '0);
      cc_sf_q <= alu_ans[W-1];
      cc_of_q <= alu_ovf;
    end
  end

  assign cc_zf = cc_zf_q;
  assign cc_sf = cc_sf_q;
  assign cc_of = cc_of_q;
`else
  assign cc_zf = 1'b0;
  assign cc_sf = 1'b0;
  assign cc_of = 1'b0;
`endif

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational 64-bit ALU (2-bit op: 00 ADD, 01 SUB, 10 AND, 11 XOR; signed operands; `ans` plus `overflow`) between two requesters, for example the execute stage and the address-generation path.
- Accepts one operation at a time over a valid/ready handshake.
- Drives the ALU from registered operands and captures its result.
- Returns the result tagged with the requester ID.
- Optionally maintains the ZF/SF/OF condition codes.

## Interface
Parameters:
- `W`, default 64: operand and result width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  request present from requester 0 / 1.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_op`, `req1_op`  in  2  ALU op code.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  W  signed operands.
- `alu_ctrl`  out  2  op code to the ALU.
- `alu_a`, `alu_b`  out  W  operands to the ALU.
- `alu_ans`  in  W  ALU result (combinational).
- `alu_ovf`  in  1  ALU overflow (combinational).
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_id`  out  1  requester that issued the op.
- `rsp_data`  out  W  captured result.
- `rsp_ovf`  out  1  captured overflow.
- `cc_zf`, `cc_sf`, `cc_of`  out  1  condition codes.

## Operation
- FSM states:
  - IDLE: waits for a request.
  - EXEC: the ALU evaluates the latched operation.
  - RESP: holds the response until it is taken.
- Transitions:
  - IDLE → EXEC on a request handshake.
  - EXEC → RESP unconditionally after one cycle.
  - RESP → IDLE when `rsp_valid` & `rsp_ready`.
- Grant, IDLE only, combinational:
  - If exactly one `reqN_valid` is high, that requester is granted.
  - If both are high, the requester named by the priority pointer `rr` is granted.
  - `reqN_ready` = (state==IDLE) & granted N. Outside IDLE both readys are 0.
- On accept:
  - Latch op/a/b into `alu_ctrl`/`alu_a`/`alu_b`.
  - Latch the requester ID.
  - `rr` ← the other requester. `rr` changes only on accept.
- At the EXEC→RESP edge: `rsp_data` ← `alu_ans`, `rsp_ovf` ← `alu_ovf`.
- `alu_*` outputs hold their last values until the next accept. No ALU output is used outside EXEC.
- `rsp_*` outputs are stable throughout RESP.
- Requesters must not make valid depend on ready. Valid may drop while not granted; no request is lost, because nothing is latched without a handshake.
- Width rules: `rsp_data` is the raw W-bit `alu_ans`. The block does no extension, truncation or saturation.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, `rr` = 0.
  - `alu_ctrl`, `alu_a`, `alu_b`, `rsp_data` = 0.
  - `rsp_id`, `rsp_ovf`, `rsp_valid` = 0.
  - `cc_zf`, `cc_sf`, `cc_of` = 0.
- Reset in the middle of EXEC or RESP discards the operation. No response is produced and the CC are cleared.
- Accept at edge N → EXEC → capture at edge N+1 → `rsp_valid`=1 from N+1.
- If `rsp_ready` is already high, the handshake completes at edge N+2 and the next accept is possible at N+3. Peak throughput is 1 op per 3 cycles.
- `rsp_ready` low stalls in RESP indefinitely. Both `reqN_ready` stay 0 during the stall.
- A request arriving during EXEC/RESP waits; it is first considered in IDLE.
- Simultaneous valid after reset: requester 0 wins, then `rr`=1. With both requesters continuously valid, grants alternate 0,1,0,1.

## Configuration
- `ALU_ARB_CC_EN` defined: CC registers update at the EXEC→RESP edge:
  - `cc_zf` = (`alu_ans`==0)
  - `cc_sf` = `alu_ans`[W-1]
  - `cc_of` = `alu_ovf`

  CC hold their values otherwise and update for every op regardless of requester.
- `ALU_ARB_CC_EN` not defined: no CC flops are built and `cc_zf`/`cc_sf`/`cc_of` are constant 0.

## Test plan
- Reset check: with reset asserted, all outputs are 0.
- Single ADD:
  - Stimulus: `req0`, op 00, a=1, b=2, `rsp_ready`=1.
  - Response: `req0_ready` at the accept edge N; `rsp_valid` from N+1 with `rsp_data`=3, `rsp_id`=0, `rsp_ovf`=0; with CC enabled, ZF=0 SF=0 OF=0.
- Overflow:
  - Stimulus: `req1`, op 00, a=0x7FFFFFFFFFFFFFFF, b=1.
  - Response: `rsp_data`=0x8000000000000000, `rsp_ovf`=1, `rsp_id`=1; with CC enabled, SF=1 OF=1.
- Arbitration: after reset, both requesters held valid (`req0` SUB 2-1, `req1` AND 0xFF00FF00FF00FF00 & 0x0F0F0F0F0F0F0F0F).
  - Responses in order: id0 with data 1, then id1 with data 0x0F000F000F000F00.
  - Repeat with both valid again: id0 is granted next.
- Backpressure:
  - Stimulus: hold `rsp_ready`=0 for 5 cycles during XOR 0xAAAA…AA ^ 0x5555…55.
  - Response: `rsp_valid` stays high with `rsp_data`=0xFFFFFFFFFFFFFFFF and both readys stay 0; the handshake completes on the first cycle `rsp_ready`=1.
- Reset mid-EXEC: assert `rst_n`=0 one cycle after accept.
  - Response: `rsp_valid` never rises, state returns to IDLE, and CC are 0.
